// File: rtl/wb_regfile_if.sv
// Bus bundle between the writeback/decode stages and the register file:
// write port, two read ports and the pending-write scoreboard.
interface wb_regfile_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
);
    logic                RegWrite;
    logic [ADDR_W-1:0]   wb_write_reg;
    logic [DATA_W-1:0]   wb_data;
    logic [ADDR_W-1:0]   rs_addr;
    logic [ADDR_W-1:0]   rt_addr;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic                sb_set;
    logic [ADDR_W-1:0]   sb_set_reg;
    logic                stall;
    logic [NUM_REGS-1:0] busy;
    logic [31:0]         wb_count;

    modport master (
        output RegWrite, wb_write_reg, wb_data, rs_addr, rt_addr, sb_set, sb_set_reg,
        input  rs_data, rt_data, stall, busy, wb_count
    );

    modport slave (
        input  RegWrite, wb_write_reg, wb_data, rs_addr, rt_addr, sb_set, sb_set_reg,
        output rs_data, rt_data, stall, busy, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Register file with write-through bypass, a per-register pending-write
// scoreboard that drives the decode stall, and a committed-write counter.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [31:0]         wb_count_q;
    logic [31:0]         wb_count_d;
    logic                stall_raw;

    // A pending source is not a hazard when writeback delivers it this cycle.
    function automatic logic hazard(
        input logic [NUM_REGS-1:0] busy,
        input logic                we,
        input logic [ADDR_W-1:0]   wa,
        input logic [ADDR_W-1:0]   a
    );
        return busy[a] && !(we && (wa == a));
    endfunction

    always_comb begin
        stall_raw = hazard(busy_q, bus.RegWrite, bus.wb_write_reg, bus.rs_addr) ||
                    hazard(busy_q, bus.RegWrite, bus.wb_write_reg, bus.rt_addr);
        bus.stall = rst_n && stall_raw;

        bus.rs_data = '0;
        if (rst_n && (bus.rs_addr != '0)) begin
            if (bus.RegWrite && (bus.wb_write_reg == bus.rs_addr)) bus.rs_data = bus.wb_data;
            else                                                   bus.rs_data = regs_q[bus.rs_addr];
        end

        bus.rt_data = '0;
        if (rst_n && (bus.rt_addr != '0)) begin
            if (bus.RegWrite && (bus.wb_write_reg == bus.rt_addr)) bus.rt_data = bus.wb_data;
            else                                                   bus.rt_data = regs_q[bus.rt_addr];
        end
    end

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        wb_count_d = wb_count_q;

        if (bus.RegWrite && (bus.wb_write_reg != '0)) begin
            regs_d[bus.wb_write_reg] = bus.wb_data;
            wb_count_d               = wb_count_q + 32'd1;
        end

        // Clear first so a same-cycle issue to the same register re-arms it.
        if (bus.RegWrite) busy_d[bus.wb_write_reg] = 1'b0;
        if (bus.sb_set && !stall_raw && (bus.sb_set_reg != '0)) busy_d[bus.sb_set_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.wb_count = wb_count_q;

endmodule
